// File: rtl/isa_io_target.sv
// ============================================================================
// Module   : isa_io_target
// Purpose  : ISA I/O-space responder turning nIOR/nIOW strobes into local
//            register requests with IOCHRDY wait-state insertion.
// Options  : define ISA_TIMEOUT_EN to force completion after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isa_io_target #(
  parameter logic [9:0] BASE_ADDR   = 10'h300,
  parameter logic [9:0] ADDR_MASK   = 10'h3F8,
  parameter int         REG_BITS    = 3,
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nIOR,
  input  logic                nIOW,
  input  logic [9:0]          SA,
  input  logic [7:0]          SD_in,
  output logic [7:0]          SD_out,
  output logic                SD_oe,
  output logic                nIOCHRDY_drv,
  output logic [REG_BITS-1:0] reg_addr,
  output logic [7:0]          reg_wdata,
  output logic                reg_we,
  output logic                reg_re,
  input  logic [7:0]          reg_rdata,
  input  logic                reg_ack,
  output logic                timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_HOLD = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_HOLD = 3'd4;

  localparam int c_SET_W = $clog2(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || TIMEOUT < 1 || TIMEOUT > 31) begin : g_param_check
    $error("isa_io_target: SYNC_STAGES must be >= 2 and TIMEOUT in 1..31");
  end

  logic [2:0]             r_state;
  logic [SYNC_STAGES-1:0] r_ior_sync;
  logic [SYNC_STAGES-1:0] r_iow_sync;
  logic                   r_ior_prev;
  logic                   r_iow_prev;
  logic [c_SET_W-1:0]     r_settle;
  logic                   r_abort;

  logic       w_ior_s;
  logic       w_iow_s;
  logic       w_settled;
  logic       w_ior_start;
  logic       w_iow_start;
  logic       w_match;
  logic       w_both_low;
  logic       w_timeout;
  logic       w_done;
  logic [7:0] w_rd_data;

  assign w_ior_s   = r_ior_sync[SYNC_STAGES-1];
  assign w_iow_s   = r_iow_sync[SYNC_STAGES-1];
  assign w_settled = (r_settle == c_SET_W'(SYNC_STAGES));

  // Edge history is held low until the chains have flushed out their reset
  // value, so a strobe still low across reset never looks like a new start.
  assign w_ior_start = w_settled && !w_ior_s && r_ior_prev;
  assign w_iow_start = w_settled && !w_iow_s && r_iow_prev;
  assign w_match     = ((SA & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  assign w_both_low  = !w_ior_s && !w_iow_s;
  assign w_done      = reg_ack || w_timeout;
  assign w_rd_data   = reg_ack ? reg_rdata : 8'hFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ior_sync <= '1;
      r_iow_sync <= '1;
      r_ior_prev <= 1'b0;
      r_iow_prev <= 1'b0;
      r_settle   <= '0;
    end else begin
      r_ior_sync <= {r_ior_sync[SYNC_STAGES-2:0], nIOR};
      r_iow_sync <= {r_iow_sync[SYNC_STAGES-2:0], nIOW};
      r_ior_prev <= w_settled ? w_ior_s : 1'b0;
      r_iow_prev <= w_settled ? w_iow_s : 1'b0;
      if (!w_settled) begin
        r_settle <= r_settle + c_SET_W'(1);
      end
    end
  end

`ifdef ISA_TIMEOUT_EN
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_next;
  logic       r_timeout_err;
  logic       w_in_req;

  assign w_in_req    = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign w_cnt_next  = (r_cnt == 5'(TIMEOUT)) ? r_cnt : r_cnt + 5'd1;
  assign w_timeout   = w_in_req && (w_cnt_next == 5'(TIMEOUT));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= 5'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt <= w_in_req ? w_cnt_next : 5'd0;
      if (w_timeout && !reg_ack) begin
        r_timeout_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_abort      <= 1'b0;
      SD_out       <= 8'h00;
      SD_oe        <= 1'b0;
      nIOCHRDY_drv <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= 8'h00;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
    end else begin
      reg_re <= 1'b0;
      reg_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          if (!w_both_low && w_match && (w_ior_start || w_iow_start)) begin
            reg_addr     <= SA[REG_BITS-1:0];
            reg_wdata    <= SD_in;
            nIOCHRDY_drv <= 1'b1;
            if (w_ior_start) begin
              r_state <= S_RD_REQ;
              reg_re  <= 1'b1;
            end else begin
              r_state <= S_WR_REQ;
              reg_we  <= 1'b1;
            end
          end
        end
        S_RD_REQ: begin
          if (w_ior_s) begin
            r_abort <= 1'b1;
          end
          if (w_done) begin
            nIOCHRDY_drv <= 1'b0;
            // Host already dropped the strobe: nobody is left to read SD.
            if (r_abort || w_ior_s) begin
              r_state <= S_IDLE;
            end else begin
              SD_out  <= w_rd_data;
              SD_oe   <= 1'b1;
              r_state <= S_RD_HOLD;
            end
          end
        end
        S_RD_HOLD: begin
          if (w_ior_s) begin
            SD_oe   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WR_REQ: begin
          if (w_iow_s) begin
            r_abort <= 1'b1;
          end
          if (w_done) begin
            nIOCHRDY_drv <= 1'b0;
            r_state      <= (r_abort || w_iow_s) ? S_IDLE : S_WR_HOLD;
          end
        end
        S_WR_HOLD: begin
          if (w_iow_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_isa_io_target.sv
// ============================================================================
// Module   : tb_isa_io_target
// Purpose  : directed self-checking bench for isa_io_target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isa_io_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       nIOR;
  logic       nIOW;
  logic [9:0] SA;
  logic [7:0] SD_in;
  logic [7:0] SD_out;
  logic       SD_oe;
  logic       nIOCHRDY_drv;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;
  int re_cnt   = 0;
  int we_cnt   = 0;
  bit seen_drv = 1'b0;
  bit seen_oe  = 1'b0;
  int re0;
  int we0;
  int n_hi;

  always #5 clk = ~clk;

  isa_io_target dut (
    .clk          (clk),
    .reset        (reset),
    .nIOR         (nIOR),
    .nIOW         (nIOW),
    .SA           (SA),
    .SD_in        (SD_in),
    .SD_out       (SD_out),
    .SD_oe        (SD_oe),
    .nIOCHRDY_drv (nIOCHRDY_drv),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .reg_ack      (reg_ack),
    .timeout_err  (timeout_err)
  );

  always @(posedge clk) begin
    if (reg_re === 1'b1) re_cnt++;
    if (reg_we === 1'b1) we_cnt++;
    if (nIOCHRDY_drv === 1'b1) seen_drv = 1'b1;
    if (SD_oe === 1'b1) seen_oe = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; nIOR = 1'b1; nIOW = 1'b1; SA = 10'h000; SD_in = 8'h00;
    reg_ack = 1'b0; reg_rdata = 8'h00;
    wait_n(3);
    check_eq("rst_sd_out", 32'(SD_out), 32'h00);
    check_eq("rst_sd_oe", 32'(SD_oe), 32'h0);
    check_eq("rst_rdy", 32'(nIOCHRDY_drv), 32'h0);
    check_eq("rst_re_we", 32'({reg_re, reg_we}), 32'h0);
    check_eq("rst_tmo", 32'(timeout_err), 32'h0);
    reset = 1'b0;
    wait_n(6);

    // Matched read, ack two cycles after reg_re.
    SA = 10'h302; nIOR = 1'b0; re0 = re_cnt;
    wait_n(2); check_eq("rd_re_early", 32'(reg_re), 32'h0);
    wait_n(1); check_eq("rd_re_pulse", 32'(reg_re), 32'h1);
    check_eq("rd_addr", 32'(reg_addr), 32'h2);
    check_eq("rd_rdy_hi", 32'(nIOCHRDY_drv), 32'h1);
    wait_n(1); check_eq("rd_re_single", 32'(reg_re), 32'h0);
    wait_n(1); check_eq("rd_rdy_ack_cyc", 32'(nIOCHRDY_drv), 32'h1);
    reg_ack = 1'b1; reg_rdata = 8'hA5;
    wait_n(1); reg_ack = 1'b0; reg_rdata = 8'h00;
    check_eq("rd_rdy_rel", 32'(nIOCHRDY_drv), 32'h0);
    check_eq("rd_oe", 32'(SD_oe), 32'h1);
    check_eq("rd_data", 32'(SD_out), 32'hA5);
    wait_n(13);
    check_eq("rd_oe_hold", 32'(SD_oe), 32'h1);
    check_eq("rd_data_hold", 32'(SD_out), 32'hA5);
    wait_n(1); nIOR = 1'b1;
    wait_n(3); check_eq("rd_oe_off", 32'(SD_oe), 32'h0);
    check_eq("rd_re_count", 32'(re_cnt - re0), 32'h1);
    wait_n(3);

    // Matched write with ack in the request cycle.
    SA = 10'h307; SD_in = 8'h3C; nIOW = 1'b0; we0 = we_cnt;
    wait_n(3); check_eq("wr_we_pulse", 32'(reg_we), 32'h1);
    check_eq("wr_addr", 32'(reg_addr), 32'h7);
    check_eq("wr_wdata", 32'(reg_wdata), 32'h3C);
    check_eq("wr_rdy_hi", 32'(nIOCHRDY_drv), 32'h1);
    reg_ack = 1'b1;
    wait_n(1); reg_ack = 1'b0;
    check_eq("wr_rdy_rel", 32'(nIOCHRDY_drv), 32'h0);
    check_eq("wr_we_single", 32'(reg_we), 32'h0);
    check_eq("wr_oe", 32'(SD_oe), 32'h0);
    wait_n(4); nIOW = 1'b1;
    wait_n(4); check_eq("wr_we_count", 32'(we_cnt - we0), 32'h1);

    // Second read: ack in the same cycle as reg_re.
    SA = 10'h305; nIOR = 1'b0;
    wait_n(3); check_eq("rd2_re", 32'(reg_re), 32'h1);
    check_eq("rd2_addr", 32'(reg_addr), 32'h5);
    reg_ack = 1'b1; reg_rdata = 8'h5A;
    wait_n(1); reg_ack = 1'b0; reg_rdata = 8'h00;
    check_eq("rd2_data", 32'(SD_out), 32'h5A);
    check_eq("rd2_rdy_rel", 32'(nIOCHRDY_drv), 32'h0);
    nIOR = 1'b1;
    wait_n(4); check_eq("rd2_oe_off", 32'(SD_oe), 32'h0);

    // Unmatched window address.
    seen_drv = 1'b0; seen_oe = 1'b0; re0 = re_cnt; we0 = we_cnt;
    SA = 10'h310; nIOR = 1'b0;
    wait_n(8); nIOR = 1'b1;
    wait_n(4); nIOW = 1'b0;
    wait_n(8); nIOW = 1'b1;
    wait_n(4);
    check_eq("um_req", 32'((re_cnt - re0) + (we_cnt - we0)), 32'h0);
    check_eq("um_rdy", 32'(seen_drv), 32'h0);
    check_eq("um_oe", 32'(seen_oe), 32'h0);

    // Both strobes low together.
    seen_drv = 1'b0; seen_oe = 1'b0; re0 = re_cnt; we0 = we_cnt;
    SA = 10'h300; nIOR = 1'b0; nIOW = 1'b0;
    wait_n(8); nIOR = 1'b1; nIOW = 1'b1;
    wait_n(4);
    check_eq("il_req", 32'((re_cnt - re0) + (we_cnt - we0)), 32'h0);
    check_eq("il_rdy", 32'(seen_drv), 32'h0);
    check_eq("il_oe", 32'(seen_oe), 32'h0);

`ifdef ISA_TIMEOUT_EN
    // Read with no ack: forced completion.
    SA = 10'h301; nIOR = 1'b0; n_hi = 0;
    wait_n(3); check_eq("to_re", 32'(reg_re), 32'h1);
    for (int i = 0; i < 40; i++) begin
      if (nIOCHRDY_drv) n_hi++;
      wait_n(1);
    end
    check_eq("to_rdy_cycles", 32'(n_hi), 32'd31);
    check_eq("to_data", 32'(SD_out), 32'hFF);
    check_eq("to_oe", 32'(SD_oe), 32'h1);
    check_eq("to_err", 32'(timeout_err), 32'h1);
    nIOR = 1'b1;
    wait_n(4);
    SA = 10'h300; nIOR = 1'b0;
    wait_n(3); reg_ack = 1'b1; reg_rdata = 8'h11;
    wait_n(1); reg_ack = 1'b0;
    check_eq("to_good_data", 32'(SD_out), 32'h11);
    nIOR = 1'b1;
    wait_n(4); check_eq("to_err_sticky", 32'(timeout_err), 32'h1);
`else
    check_eq("no_to_err", 32'(timeout_err), 32'h0);
`endif

    // Reset while holding read data.
    SA = 10'h303; nIOR = 1'b0;
    wait_n(3); reg_ack = 1'b1; reg_rdata = 8'hC3;
    wait_n(1); reg_ack = 1'b0;
    check_eq("mr_oe_pre", 32'(SD_oe), 32'h1);
    reset = 1'b1;
    wait_n(1);
    check_eq("mr_oe", 32'(SD_oe), 32'h0);
    check_eq("mr_rdy", 32'(nIOCHRDY_drv), 32'h0);
    check_eq("mr_sd_out", 32'(SD_out), 32'h00);
    reset = 1'b0; re0 = re_cnt;
    wait_n(10);
    check_eq("mr_no_reissue", 32'(re_cnt - re0), 32'h0);
    check_eq("mr_rdy_idle", 32'(nIOCHRDY_drv), 32'h0);
    nIOR = 1'b1;
    wait_n(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
